// File: rtl/priority_encoder_32.sv
// Sticky request collector with fixed-priority encode and valid/ready offer.
// Requests latch into pending bits; the lowest-numbered pending, unmasked bit
// is offered as an index and retired when the consumer accepts it.
module priority_encoder_32 #(
  parameter int N = 32,
  parameter int W = 5
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [N-1:0] req,
  input  logic [N-1:0] clr,
  input  logic [N-1:0] mask,
  output logic [W-1:0] out_index,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] pending
);

  logic [N-1:0] pending_q, pending_d;
  logic [W-1:0] index_q, index_d;
  logic         valid_q, valid_d;

  logic         fire;
  logic         load;
  logic [N-1:0] ack;
  logic [N-1:0] cand;

  // Lowest set bit position of vec, zero when vec is empty.
  function automatic logic [W-1:0] lowest_index(input logic [N-1:0] vec);
    logic [W-1:0] idx;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = W'(i);
    end
    return idx;
  endfunction

  // Handshake terms, candidate set and next-state for pending and the offer.
  always_comb begin
    fire      = valid_q & out_ready;
    ack       = fire ? (N'(1) << index_q) : '0;
    cand      = pending_q & mask & ~ack;
    load      = ~valid_q | fire;
    // A same-cycle set wins over both the acceptance and an explicit clear.
    pending_d = (pending_q & ~ack & ~clr) | req;
    valid_d   = valid_q;
    index_d   = index_q;
    if (load) begin
      valid_d = |cand;
      index_d = lowest_index(cand);
    end
  end

  // State registers; reset drops any offer in flight without retiring it.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pending_q <= '0;
      valid_q   <= 1'b0;
      index_q   <= '0;
    end else begin
      pending_q <= pending_d;
      valid_q   <= valid_d;
      index_q   <= index_d;
    end
  end

  assign out_index = index_q;
  assign out_valid = valid_q;
  assign pending   = pending_q;

endmodule

// File: doc/priority_encoder_32.md
Name: priority_encoder_32

Overview:
- Sequential counterpart to the processor's 5-to-32 one-hot decode: collects up to 32 request lines into sticky pending bits.
- Each cycle it encodes the lowest-numbered pending, unmasked request into a 5-bit index.
- The index is delivered over a valid/ready handshake, and the bit is retired on acceptance.
- Sits between interrupt/event sources and the control unit, which consumes one encoded index per handshake.

Parameters:
- N, 32, number of request lines
- W, 5, index width; must equal clog2(N)

Ports:
- clock  input  1  system clock, all state updates on rising edge
- reset_n  input  1  synchronous active-low reset, sampled on rising edge of clock
- req  input  N  request set pulses; bit i high for one or more cycles sets pending[i]
- clr  input  N  explicit clear; bit i high clears pending[i]
- mask  input  N  enable; bit i low excludes pending[i] from selection (bit stays pending)
- out_index  output  W  encoded index of the offered request
- out_valid  output  1  out_index holds a valid offer
- out_ready  input  1  consumer accepts the offer when high together with out_valid
- pending  output  N  registered pending vector (status)

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset: when reset_n = 0 at an edge, pending = 0, out_valid = 0, out_index = 0. Reset takes effect mid-handshake; an offer in flight is dropped and not retired.
- Per-cycle terms:
  - fire = out_valid & out_ready.
  - ack = one-hot of out_index when fire, else 0.
  - cand = pending & mask & ~ack.
- Pending update: pending_next = (pending & ~ack & ~clr) | req.
  - Set has priority over ack and clr on the same bit in the same cycle.
- Output register:
  - Loads when out_valid = 0 or fire = 1.
  - On load: out_valid <= |cand; out_index <= lowest i with cand[i] = 1, or 0 if cand = 0.
  - Holds unchanged when out_valid = 1 and out_ready = 0.
  - No retraction: out_index and out_valid stay stable even if mask or clr later remove that bit.
  - An accepted offer whose pending bit was already cleared retires nothing further.
- Priority: fixed, index 0 highest, index N-1 lowest.
  - A newly pending lower index never pre-empts a held offer. It is considered at the next load.
- Latency:
  - req asserted in cycle t -> pending set at edge t+1 -> out_valid at edge t+2 (if the output register is loadable).
  - Throughput is one accepted index per cycle with out_ready held high. The ~ack term prevents re-offering a just-accepted bit.
- Width rules: out_index is zero-extended from the selected bit position. No arithmetic overflow is possible.
- Empty: cand = 0 at a load edge -> out_valid = 0, out_index = 0.
- All-pending: 32 bits pending and all masked in, out_ready = 1 -> indices 0,1,...,31 on consecutive cycles, then out_valid = 0.
- Re-request: req[i] in the same cycle as its ack leaves pending[i] = 1. Index i is re-offered no earlier than the following load.

Test Plan:
- Reset with req = 0xFFFFFFFF held, reset_n = 0 for 2 cycles -> pending = 0, out_valid = 0, out_index = 0. First release edge sets pending = 0xFFFFFFFF; out_valid rises one edge later with out_index = 0.
- req = 0x00000005 pulse, mask all ones, out_ready = 1 -> out_index 0 offered at t+2, index 2 at t+3, out_valid = 0 at t+4, pending = 0 at t+4.
- out_ready = 0, pending = 0x80000010 -> out_index = 4 held stable. Assert req[1]: offer stays 4. Raise out_ready: next offer 1, then 31.
- mask = 0xFFFFFFFE with pending[0] and pending[3] set -> offer index 3. pending[0] remains set; clear mask bit 0 back to 1 -> index 0 offered at the next load.
- Same-cycle conflict: fire on index 7 while req[7] = 1 and clr[7] = 1 -> pending[7] = 1 after the edge. Index 7 is re-offered, not immediately back-to-back with the ack.
- Reset mid-handshake: out_valid = 1 (index 9), out_ready = 0, reset_n pulsed low -> all outputs 0. pending[9] = 0; no index is delivered.
